// File: rtl/weight_config_loader_if.sv
// Upstream word stream into the weight configuration loader.
// The producer drives valid/data; the loader drives ready.
interface weight_config_loader_if;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready
  );
endinterface

// File: rtl/weight_config_loader.sv
// Parses layer/neuron/count headed packets and broadcasts each weight word with its index.
// Packets whose count exceeds max_weights are consumed silently and flagged with err.
module weight_config_loader #(
  parameter int unsigned max_weights  = 784,
  parameter int unsigned address_bits = $clog2(max_weights)
) (
  input  logic                    clk,
  input  logic                    reset,
  weight_config_loader_if.slave   s,
  output logic                    weight_valid,
  output logic [31:0]             weight_value,
  output logic [31:0]             config_layer_no,
  output logic [31:0]             config_neuron_no,
  output logic [address_bits-1:0] weight_index,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  typedef enum logic [2:0] {StIdle, StHdrNeuron, StHdrCount, StData, StDrop} state_e;

  state_e                  state_q, state_d;
  logic [31:0]             remaining_q, remaining_d;
  logic [address_bits-1:0] index_q, index_d;
  logic [31:0]             layer_q, layer_d;
  logic [31:0]             neuron_q, neuron_d;
  logic                    wvalid_q, wvalid_d;
  logic [31:0]             wvalue_q, wvalue_d;
  logic [address_bits-1:0] widx_q, widx_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    accept;

  // Never back-pressures; ready only drops while reset is held.
  assign s.s_ready = reset;
  assign accept    = s.s_valid & s.s_ready;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    index_d     = index_q;
    layer_d     = layer_q;
    neuron_d    = neuron_q;
    wvalid_d    = 1'b0;
    wvalue_d    = wvalue_q;
    widx_d      = widx_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    if (accept) begin
      unique case (state_q)
        StIdle: begin
          layer_d = s.s_data;
          state_d = StHdrNeuron;
        end
        StHdrNeuron: begin
          neuron_d = s.s_data;
          state_d  = StHdrCount;
        end
        StHdrCount: begin
          if (s.s_data == 32'd0) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else if (s.s_data <= 32'(max_weights)) begin
            remaining_d = s.s_data;
            index_d     = '0;
            state_d     = StData;
          end else begin
            err_d       = 1'b1;
            remaining_d = s.s_data;
            state_d     = StDrop;
          end
        end
        StData: begin
          wvalid_d    = 1'b1;
          wvalue_d    = s.s_data;
          widx_d      = index_q;
          index_d     = index_q + address_bits'(1);
          remaining_d = remaining_q - 32'd1;
          if (remaining_q == 32'd1) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
        StDrop: begin
          remaining_d = remaining_q - 32'd1;
          if (remaining_q == 32'd1) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      index_q     <= '0;
      layer_q     <= '0;
      neuron_q    <= '0;
      wvalid_q    <= 1'b0;
      wvalue_q    <= '0;
      widx_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      index_q     <= index_d;
      layer_q     <= layer_d;
      neuron_q    <= neuron_d;
      wvalid_q    <= wvalid_d;
      wvalue_q    <= wvalue_d;
      widx_q      <= widx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign weight_valid     = wvalid_q;
  assign weight_value     = wvalue_q;
  assign config_layer_no  = layer_q;
  assign config_neuron_no = neuron_q;
  assign weight_index     = widx_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign err              = err_q;

endmodule

// File: tb/tb_weight_config_loader.sv
// Directed scenario bench for weight_config_loader; inputs change on negedge,
// outputs are sampled on the following negedge.
module tb_weight_config_loader;

  localparam int AW = 10;

  logic          clk;
  logic          reset;
  logic          weight_valid;
  logic [31:0]   weight_value;
  logic [31:0]   config_layer_no;
  logic [31:0]   config_neuron_no;
  logic [AW-1:0] weight_index;
  logic          busy;
  logic          done;
  logic          err;

  int checks;
  int errors;

  weight_config_loader_if s_if ();

  weight_config_loader dut (
    .clk              (clk),
    .reset            (reset),
    .s                (s_if.slave),
    .weight_valid     (weight_valid),
    .weight_value     (weight_value),
    .config_layer_no  (config_layer_no),
    .config_neuron_no (config_neuron_no),
    .weight_index     (weight_index),
    .busy             (busy),
    .done             (done),
    .err              (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {busy, weight_valid, done, err, weight_index, weight_value}
  function automatic logic [45:0] obs();
    return {busy, weight_valid, done, err, weight_index, weight_value};
  endfunction

  // Present one word for exactly one edge; returns on the next negedge.
  task automatic put(input logic [31:0] d);
    s_if.s_valid = 1'b1;
    s_if.s_data  = d;
    @(negedge clk);
    s_if.s_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    s_if.s_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [110:0] got;
    reset        = 1'b1;
    s_if.s_valid = 1'b0;
    s_if.s_data  = 32'd0;
    #2 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    got = {s_if.s_ready, obs(), config_layer_no, config_neuron_no};
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL reset_values got %h exp 0", got);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (s_if.s_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset got %b exp 1", s_if.s_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [45:0] exp;
    put(32'd1);
    checks++;
    if ({busy, weight_valid, config_layer_no} !== {1'b1, 1'b0, 32'd1}) begin
      errors++;
      $display("FAIL basic_layer got %b %b %0d exp 1 0 1", busy, weight_valid, config_layer_no);
    end
    put(32'd5);
    checks++;
    if (config_neuron_no !== 32'd5) begin
      errors++;
      $display("FAIL basic_neuron got %0d exp 5", config_neuron_no);
    end
    put(32'd3);
    put(32'hA);
    exp = {1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 32'hA};
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL basic_w0 got %h exp %h", obs(), exp);
    end
    put(32'hB);
    exp = {1'b1, 1'b1, 1'b0, 1'b0, 10'd1, 32'hB};
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL basic_w1 got %h exp %h", obs(), exp);
    end
    put(32'hC);
    exp = {1'b0, 1'b1, 1'b1, 1'b0, 10'd2, 32'hC};
    checks++;
    if ({obs(), config_layer_no, config_neuron_no} !== {exp, 32'd1, 32'd5}) begin
      errors++;
      $display("FAIL basic_w2 got %h %0d %0d exp %h 1 5", obs(), config_layer_no,
               config_neuron_no, exp);
    end
    idle_cycle();
    checks++;
    if ({busy, weight_valid, done, err} !== 4'b0000) begin
      errors++;
      $display("FAIL basic_after got %b exp 0000", {busy, weight_valid, done, err});
    end
  endtask

  task automatic test_gap();
    logic [45:0] exp;
    put(32'd1);
    put(32'd5);
    put(32'd3);
    put(32'hA);
    exp = {1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 32'hA};
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL gap_w0 got %h exp %h", obs(), exp);
    end
    for (int i = 0; i < 4; i++) begin
      idle_cycle();
      exp = {1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 32'hA};
      checks++;
      if (obs() !== exp) begin
        errors++;
        $display("FAIL gap_hold%0d got %h exp %h", i, obs(), exp);
      end
    end
    put(32'hB);
    exp = {1'b1, 1'b1, 1'b0, 1'b0, 10'd1, 32'hB};
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL gap_w1 got %h exp %h", obs(), exp);
    end
    put(32'hC);
    exp = {1'b0, 1'b1, 1'b1, 1'b0, 10'd2, 32'hC};
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL gap_w2 got %h exp %h", obs(), exp);
    end
    idle_cycle();
  endtask

  task automatic test_zero_count();
    put(32'd2);
    put(32'd7);
    put(32'd0);
    checks++;
    if ({busy, weight_valid, done, err, config_layer_no, config_neuron_no} !==
        {4'b0010, 32'd2, 32'd7}) begin
      errors++;
      $display("FAIL zero_done got %b %0d %0d exp 0010 2 7", {busy, weight_valid, done, err},
               config_layer_no, config_neuron_no);
    end
    idle_cycle();
    checks++;
    if ({busy, weight_valid, done, err} !== 4'b0000) begin
      errors++;
      $display("FAIL zero_after got %b exp 0000", {busy, weight_valid, done, err});
    end
  endtask

  task automatic test_drop();
    int err_seen;
    int wv_seen;
    put(32'd0);
    put(32'd0);
    put(32'd785);
    checks++;
    if ({busy, weight_valid, done, err} !== 4'b1001) begin
      errors++;
      $display("FAIL drop_err got %b exp 1001", {busy, weight_valid, done, err});
    end
    err_seen = 0;
    wv_seen  = 0;
    for (int i = 0; i < 784; i++) begin
      put(32'(i + 100));
      if (err) err_seen++;
      if (weight_valid) wv_seen++;
      checks++;
      if ({busy, done} !== 2'b10) begin
        errors++;
        $display("FAIL drop_word%0d got %b exp 10", i, {busy, done});
      end
    end
    put(32'hDEAD);
    checks++;
    if ({busy, weight_valid, done, err} !== 4'b0010) begin
      errors++;
      $display("FAIL drop_last got %b exp 0010", {busy, weight_valid, done, err});
    end
    checks++;
    if ({err_seen, wv_seen} !== {32'd0, 32'd0}) begin
      errors++;
      $display("FAIL drop_pulses got err=%0d wv=%0d exp 0 0", err_seen, wv_seen);
    end
    idle_cycle();
  endtask

  task automatic test_reset_mid();
    logic [45:0] exp;
    put(32'd1);
    put(32'd1);
    put(32'd784);
    for (int i = 0; i < 100; i++) put(32'(i + 32'h1000));
    exp = {1'b1, 1'b1, 1'b0, 1'b0, 10'd99, 32'h1063};
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL mid_w99 got %h exp %h", obs(), exp);
    end
    s_if.s_valid = 1'b1;
    s_if.s_data  = 32'h2000;
    reset        = 1'b0;
    #1;
    checks++;
    if ({s_if.s_ready, obs(), config_layer_no, config_neuron_no} !== '0) begin
      errors++;
      $display("FAIL mid_async got %h %0d %0d exp 0", obs(), config_layer_no, config_neuron_no);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (obs() !== '0) begin
      errors++;
      $display("FAIL mid_held got %h exp 0", obs());
    end
    s_if.s_valid = 1'b0;
    reset        = 1'b1;
    put(32'd3);
    put(32'd4);
    put(32'd1);
    put(32'h55);
    exp = {1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 32'h55};
    checks++;
    if ({obs(), config_layer_no, config_neuron_no} !== {exp, 32'd3, 32'd4}) begin
      errors++;
      $display("FAIL mid_next got %h %0d %0d exp %h 3 4", obs(), config_layer_no,
               config_neuron_no, exp);
    end
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    logic [45:0] exp;
    put(32'd6);
    put(32'd8);
    put(32'd2);
    put(32'h11);
    put(32'h22);
    exp = {1'b0, 1'b1, 1'b1, 1'b0, 10'd1, 32'h22};
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL b2b_first got %h exp %h", obs(), exp);
    end
    put(32'd9);
    checks++;
    if ({busy, weight_valid, done, config_layer_no, config_neuron_no} !==
        {3'b100, 32'd9, 32'd8}) begin
      errors++;
      $display("FAIL b2b_hdr got %b %0d %0d exp 100 9 8", {busy, weight_valid, done},
               config_layer_no, config_neuron_no);
    end
    put(32'd10);
    put(32'd1);
    put(32'h33);
    exp = {1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 32'h33};
    checks++;
    if ({obs(), config_layer_no, config_neuron_no} !== {exp, 32'd9, 32'd10}) begin
      errors++;
      $display("FAIL b2b_second got %h %0d %0d exp %h 9 10", obs(), config_layer_no,
               config_neuron_no, exp);
    end
    idle_cycle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_gap();
    test_zero_count();
    test_drop();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
